// File: rtl/mux_rr_n.sv
// N-channel registered selector with valid/ready handshakes.
// Mode 0 selects the channel on Sel; mode 1 arbitrates round-robin over the valid channels.
module mux_rr_n #(
    parameter  int WIDTH = 16,
    parameter  int N     = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [N*WIDTH-1:0]   In,
    input  logic [N-1:0]         InValid,
    output logic [N-1:0]         InReady,
    input  logic                 Mode,
    input  logic [SEL_W-1:0]     Sel,
    output logic [WIDTH-1:0]     Out,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [SEL_W-1:0]     OutSel
);

    logic [SEL_W-1:0] ptr;
    logic             load;
    logic             cand_valid;
    logic [SEL_W-1:0] cand_idx;
    logic             grant;
    logic [WIDTH-1:0] grant_data;
    int               best_off;
    int               off;

    // Candidate selection: the Sel channel in direct mode; otherwise the valid
    // channel nearest to ptr going upward with wrap, found as the minimum cyclic
    // distance so the channel index is always a loop constant.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
        load       = !OutValid || OutReady;
        cand_valid = 1'b0;
        cand_idx   = '0;
        best_off   = N;
        off        = 0;
        if (!Mode) begin
            for (int i = 0; i < N; i++) begin
                if (int'(Sel) == i && InValid[i]) begin
                    cand_valid = 1'b1;
                    cand_idx   = SEL_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                off = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + N - int'(ptr));
                if (InValid[i] && off < best_off) begin
                    best_off   = off;
                    cand_valid = 1'b1;
                    cand_idx   = SEL_W'(i);
                end
            end
        end
        grant = cand_valid && load && !Reset;
    end

    always_comb begin
        InReady    = '0;
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (cand_idx == SEL_W'(i)) begin
                InReady[i] = grant;
                grant_data = In[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge Clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (Reset) begin
            Out      <= '0;
            OutValid <= 1'b0;
            OutSel   <= '0;
            ptr      <= '0;
        end else begin
            if (load) begin
                if (grant) begin
                    Out      <= grant_data;
                    OutSel   <= cand_idx;
                    OutValid <= 1'b1;
                end else begin
                    OutValid <= 1'b0;
                end
            end
            // Explicit wrap keeps ptr inside 0..N-1 when N is not a power of two.
            if (grant && Mode) begin
                ptr <= (cand_idx == SEL_W'(N - 1)) ? '0 : cand_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_n.sv
// Bench for mux_rr_n: an N=8 and an N=5 instance, each checked every cycle
// against a behavioural model, plus directed expectations written out by hand.
module tb_mux_rr_n;

    logic        Clk = 1'b0;
    logic        Reset;
    always #5 Clk = ~Clk;

    logic [127:0] in8;
    logic [7:0]   iv8, ir8;
    logic         mode8, ov8, ordy8;
    logic [2:0]   sel8, os8;
    logic [15:0]  out8;

    logic [79:0]  in5;
    logic [4:0]   iv5, ir5;
    logic         mode5, ov5, ordy5;
    logic [2:0]   sel5, os5;
    logic [15:0]  out5;

    mux_rr_n #(.WIDTH(16), .N(8)) dut8 (
        .Clk(Clk), .Reset(Reset), .In(in8), .InValid(iv8), .InReady(ir8),
        .Mode(mode8), .Sel(sel8), .Out(out8), .OutValid(ov8),
        .OutReady(ordy8), .OutSel(os8)
    );

    mux_rr_n #(.WIDTH(16), .N(5)) dut5 (
        .Clk(Clk), .Reset(Reset), .In(in5), .InValid(iv5), .InReady(ir5),
        .Mode(mode5), .Sel(sel5), .Out(out5), .OutValid(ov5),
        .OutReady(ordy5), .OutSel(os5)
    );

    int checks   = 0;
    int failures = 0;
    bit armed    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which channel the rules choose, or -1: Sel when in range and valid, else the
    // first valid channel counting cyclically from ptr.
    function automatic int pick(input int n, input logic mode, input int sel,
                                input logic [31:0] valid, input int ptr);
        if (!mode)
            return (sel < n && ((valid >> sel) & 32'd1) != 0) ? sel : -1;
        for (int k = 0; k < n; k++) begin
            automatic int c = (ptr + k) % n;
            if (((valid >> c) & 32'd1) != 0) return c;
        end
        return -1;
    endfunction

    // Model state for each instance.
    logic [15:0] m8_out, m5_out;
    bit          m8_v, m5_v;
    int          m8_sel, m5_sel, m8_ptr, m5_ptr;
    int          g8, g5;
    bit          ld8, ld5;

    always_comb begin
        ld8 = !m8_v || ordy8;
        ld5 = !m5_v || ordy5;
        g8  = pick(8, mode8, int'(sel8), 32'(iv8), m8_ptr);
        g5  = pick(5, mode5, int'(sel5), 32'(iv5), m5_ptr);
    end

    always @(posedge Clk) begin
        if (Reset) begin
            m8_out <= '0; m8_v <= 1'b0; m8_sel <= 0; m8_ptr <= 0;
            m5_out <= '0; m5_v <= 1'b0; m5_sel <= 0; m5_ptr <= 0;
            armed  <= 1'b1;
        end else begin
            if (ld8) begin
                if (g8 >= 0) begin
                    m8_out <= in8[g8*16 +: 16];
                    m8_sel <= g8;
                    m8_v   <= 1'b1;
                    if (mode8) m8_ptr <= (g8 + 1) % 8;
                end else begin
                    m8_v <= 1'b0;
                end
            end
            if (ld5) begin
                if (g5 >= 0) begin
                    m5_out <= in5[g5*16 +: 16];
                    m5_sel <= g5;
                    m5_v   <= 1'b1;
                    if (mode5) m5_ptr <= (g5 + 1) % 5;
                end else begin
                    m5_v <= 1'b0;
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (armed) begin
            check("model_ready8", 32'(ir8), (!Reset && ld8 && g8 >= 0) ? (32'd1 << g8) : 32'd0);
            check("model_out8",   32'(out8), 32'(m8_out));
            check("model_valid8", 32'(ov8),  32'(m8_v));
            check("model_sel8",   32'(os8),  32'(m8_sel));
            check("model_ready5", 32'(ir5), (!Reset && ld5 && g5 >= 0) ? (32'd1 << g5) : 32'd0);
            check("model_out5",   32'(out5), 32'(m5_out));
            check("model_valid5", 32'(ov5),  32'(m5_v));
            check("model_sel5",   32'(os5),  32'(m5_sel));
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    int rr8_exp[6] = '{0, 2, 7, 0, 2, 7};
    int rr5_exp[4] = '{0, 4, 0, 4};

    initial begin
        Reset = 1'b1;
        iv8 = '1; mode8 = 1'b0; sel8 = '0; ordy8 = 1'b1;
        iv5 = '1; mode5 = 1'b0; sel5 = '0; ordy5 = 1'b1;
        for (int i = 0; i < 8; i++) in8[i*16 +: 16] = 16'h1000 + 16'(i);
        for (int i = 0; i < 5; i++) in5[i*16 +: 16] = 16'h5000 + 16'(i);

        // Reset with every channel valid, then release with nothing valid.
        tick();
        @(negedge Clk);
        check("rst_ready8", 32'(ir8), 32'h0);
        check("rst_ready5", 32'(ir5), 32'h0);
        tick();
        Reset = 1'b0; iv8 = '0; iv5 = '0;
        @(negedge Clk);
        check("rst_out8",   32'(out8), 32'h0);
        check("rst_valid8", 32'(ov8),  32'h0);
        check("rst_sel8",   32'(os8),  32'h0);
        tick();
        tick();
        @(negedge Clk);
        check("idle_valid8", 32'(ov8), 32'h0);

        // Direct sweep of Sel 0..7 with all channels valid.
        tick();
        iv8 = '1; mode8 = 1'b0;
        for (int s = 0; s < 8; s++) begin
            sel8 = 3'(s);
            @(negedge Clk);
            check("sweep_ready", 32'(ir8), 32'd1 << s);
            if (s > 0) begin
                check("sweep_out", 32'(out8), 32'h1000 + 32'(s - 1));
                check("sweep_sel", 32'(os8),  32'(s - 1));
            end
            tick();
        end
        @(negedge Clk);
        check("sweep_out_last", 32'(out8), 32'h1007);
        check("sweep_sel_last", 32'(os8),  32'd7);

        // Backpressure on channel 3.
        tick();
        sel8 = 3'd3;
        @(negedge Clk);
        tick();
        ordy8 = 1'b0;
        in8[3*16 +: 16] = 16'hBEEF;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            check("bp_hold_out", 32'(out8), 32'h1003);
            check("bp_ready",    32'(ir8),  32'h0);
            tick();
        end
        ordy8 = 1'b1;
        @(negedge Clk);
        check("bp_release_ready", 32'(ir8), 32'h08);
        tick();
        @(negedge Clk);
        check("bp_new_out", 32'(out8), 32'hBEEF);
        tick();
        in8[3*16 +: 16] = 16'h1003;

        // Round-robin over channels 0, 2, 7.
        mode8 = 1'b1; iv8 = 8'b1000_0101;
        for (int k = 0; k < 6; k++) begin
            tick();
            @(negedge Clk);
            check("rr8_sel",   32'(os8),  32'(rr8_exp[k]));
            check("rr8_out",   32'(out8), 32'h1000 + 32'(rr8_exp[k]));
            check("rr8_valid", 32'(ov8),  32'h1);
        end
        tick();
        iv8 = '0;

        // N=5: wrap from 4 to 0, then an out-of-range Sel.
        mode5 = 1'b1; iv5 = 5'b10001;
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge Clk);
            check("rr5_sel", 32'(os5),  32'(rr5_exp[k]));
            check("rr5_out", 32'(out5), 32'h5000 + 32'(rr5_exp[k]));
        end
        tick();
        mode5 = 1'b0; sel5 = 3'd6;
        @(negedge Clk);
        check("oor_ready5", 32'(ir5), 32'h0);
        tick();
        @(negedge Clk);
        check("oor_valid5", 32'(ov5), 32'h0);

        // Reset while holding a word from channel 2 under backpressure.
        tick();
        mode8 = 1'b1; iv8 = 8'b0000_0100; ordy8 = 1'b1;
        tick();
        ordy8 = 1'b0; iv8 = '0;
        @(negedge Clk);
        check("mid_sel_before",   32'(os8), 32'h2);
        check("mid_valid_before", 32'(ov8), 32'h1);
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0; iv8 = 8'b1000_0100; ordy8 = 1'b1;
        @(negedge Clk);
        check("mid_valid_after", 32'(ov8),  32'h0);
        check("mid_out_after",   32'(out8), 32'h0);
        check("mid_ready_scan0", 32'(ir8),  32'h04);
        tick();
        @(negedge Clk);
        check("mid_sel_next", 32'(os8), 32'h2);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
